// File: rtl/main_system_rst_pkg.sv
// Shared definitions for the system PLL reset controller: FSM state encodings,
// default cycle constants and a small state decode helper.
package main_system_rst_pkg;

  localparam int STATE_W = 3;

  // FSM state encodings (plain constants so they can be bound to checkers directly)
  localparam logic [STATE_W-1:0] ST_PLL_RST   = 3'd0;
  localparam logic [STATE_W-1:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [STATE_W-1:0] ST_STABLE    = 3'd2;
  localparam logic [STATE_W-1:0] ST_HOLD      = 3'd3;
  localparam logic [STATE_W-1:0] ST_RUN       = 3'd4;
  localparam logic [STATE_W-1:0] ST_FAULT     = 3'd5;

  // Default timing, in refclk cycles
  localparam int DEF_SYNC_STAGES         = 2;
  localparam int DEF_PLL_RST_CYCLES      = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 500000;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_RESET_HOLD_CYCLES   = 64;
  localparam int DEF_CNT_W               = 20;
  localparam int DEF_LOSS_CNT_W          = 8;
  localparam int DEF_MAX_RETRIES         = 3;

  // The system is held in reset everywhere except RUN
  function automatic logic holds_sys_rst(input logic [STATE_W-1:0] st);
    return (st != ST_RUN);
  endfunction

endpackage

// File: rtl/main_system_bit_sync.sv
// Multi-flop synchroniser for a single asynchronous level; all stages reset to 0
// so a stale "locked" can never leak through after reset.
module main_system_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/main_system_pll_rst_ctrl.sv
// System PLL reset controller. Pulses the PLL reset, waits for a stable lock,
// holds the system in reset for a while and then releases it. Lock loss in RUN
// drops back to waiting for lock without re-resetting the PLL; a lock timeout
// re-pulses the PLL reset. Sticky status: lock_loss_count and timeout_err.
// Handshakes: none; clear_status is a single-cycle pulse sampled on refclk.
// Optional feature macro: PLL_RSTCTRL_RETRY_LIMIT_EN -- when defined, the timeout
// that pushes the retry count past MAX_RETRIES parks the FSM in FAULT until rst.
// fsm_state exposes the current FSM state for debug.
module main_system_pll_rst_ctrl
  import main_system_rst_pkg::*;
#(
  parameter int SYNC_STAGES         = DEF_SYNC_STAGES,
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int RESET_HOLD_CYCLES   = DEF_RESET_HOLD_CYCLES,
  parameter int CNT_W               = DEF_CNT_W,
  parameter int LOSS_CNT_W          = DEF_LOSS_CNT_W,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic                  clear_status,
  output logic                  pll_rst,
  output logic                  sys_rst,
  output logic                  sys_rst_n,
  output logic                  ready,
  output logic [LOSS_CNT_W-1:0] lock_loss_count,
  output logic                  timeout_err,
  output logic                  fault,
  output logic [STATE_W-1:0]    fsm_state
);

  // Retry counter wide enough to hold MAX_RETRIES+1 without wrapping
  localparam int RETRY_W = $clog2(MAX_RETRIES + 2);

  // Counter reload values: a state lasting N cycles loads N-1 and exits at 0
  localparam logic [CNT_W-1:0] LD_PLL_RST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_TIMEOUT = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_STABLE  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_HOLD    = CNT_W'(RESET_HOLD_CYCLES - 1);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   load_val;
  logic [RETRY_W-1:0] retry_cnt;
  logic               lk;
  logic               cnt_zero;
  logic               timeout_ev;
  logic               loss_ev;

  main_system_bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk)
  );

  assign cnt_zero  = (cnt == '0);
  assign fsm_state = state;

  // Next-state decode plus the single-cycle timeout / lock-loss events
  always_comb begin
    nxt        = state;
    timeout_ev = 1'b0;
    loss_ev    = 1'b0;
    case (state)
      ST_PLL_RST: begin
        if (cnt_zero) nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lk) begin
          nxt = ST_STABLE;
        end else if (cnt_zero) begin
          timeout_ev = 1'b1;
`ifdef PLL_RSTCTRL_RETRY_LIMIT_EN
          nxt = (retry_cnt >= RETRY_W'(MAX_RETRIES)) ? ST_FAULT : ST_PLL_RST;
`else
          nxt = ST_PLL_RST;
`endif
        end
      end
      ST_STABLE: begin
        if (!lk)           nxt = ST_WAIT_LOCK;
        else if (cnt_zero) nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (!lk)           nxt = ST_WAIT_LOCK;
        else if (cnt_zero) nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!lk) begin
          nxt     = ST_WAIT_LOCK;
          loss_ev = 1'b1;
        end
      end
`ifdef PLL_RSTCTRL_RETRY_LIMIT_EN
      ST_FAULT: begin
        nxt = ST_FAULT;
      end
`endif
      default: begin
        nxt = ST_PLL_RST;
      end
    endcase
  end

  // Reload value for the shared counter, chosen by the state being entered
  always_comb begin
    load_val = '0;
    case (nxt)
      ST_PLL_RST:   load_val = LD_PLL_RST;
      ST_WAIT_LOCK: load_val = LD_TIMEOUT;
      ST_STABLE:    load_val = LD_STABLE;
      ST_HOLD:      load_val = LD_HOLD;
      default:      load_val = '0;
    endcase
  end

  // State register and shared down-counter (reloaded on every state change)
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state <= ST_PLL_RST;
      cnt   <= LD_PLL_RST;
    end else begin
      state <= nxt;
      if (nxt != state)  cnt <= load_val;
      else if (!cnt_zero) cnt <= cnt - 1'b1;
    end
  end

  // Retry count: bumps on each timeout (saturating), clears on reaching RUN
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      retry_cnt <= '0;
    end else if (nxt == ST_RUN && state != ST_RUN) begin
      retry_cnt <= '0;
    end else if (timeout_ev && retry_cnt != '1) begin
      retry_cnt <= retry_cnt + 1'b1;
    end
  end

  // Registered reset/status outputs, decoded from the state being entered
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
    end else begin
      pll_rst   <= (nxt == ST_PLL_RST);
      sys_rst   <= holds_sys_rst(nxt);
      sys_rst_n <= !holds_sys_rst(nxt);
      ready     <= (nxt == ST_RUN);
    end
  end

  // Sticky status; a clear in the same cycle as a new event still records it
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lock_loss_count <= '0;
      timeout_err     <= 1'b0;
    end else begin
      if (clear_status)
        lock_loss_count <= loss_ev ? LOSS_CNT_W'(1) : '0;
      else if (loss_ev && lock_loss_count != '1)
        lock_loss_count <= lock_loss_count + 1'b1;
      timeout_err <= (timeout_err && !clear_status) || timeout_ev;
    end
  end

`ifdef PLL_RSTCTRL_RETRY_LIMIT_EN
  // Fault flag follows entry into the terminal FAULT state
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) fault <= 1'b0;
    else     fault <= (nxt == ST_FAULT);
  end
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_main_system_pll_rst_ctrl.sv
// Bench for main_system_pll_rst_ctrl with short timing parameters
// (SYNC=2, PLL_RST=4, TIMEOUT=50, STABLE=8, HOLD=4). Inputs are driven and
// outputs sampled on the falling edge; the design acts on the rising edge.
module tb_main_system_pll_rst_ctrl;
  import main_system_rst_pkg::*;

  localparam int LAT     = 2 + 8 + 4 + 1;  // lock rise -> sys_rst fall, in edges
  localparam int PERIOD  = 4 + 50;         // pll_rst re-pulse period with no lock

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       clear_status;
  logic       pll_rst;
  logic       sys_rst;
  logic       sys_rst_n;
  logic       ready;
  logic [7:0] lock_loss_count;
  logic       timeout_err;
  logic       fault;
  logic [2:0] fsm_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  // Clock and reset block
  always #5 refclk = ~refclk;

  main_system_pll_rst_ctrl #(
    .SYNC_STAGES         (2),
    .PLL_RST_CYCLES      (4),
    .LOCK_TIMEOUT_CYCLES (50),
    .LOCK_STABLE_CYCLES  (8),
    .RESET_HOLD_CYCLES   (4),
    .CNT_W               (20),
    .LOSS_CNT_W          (8),
    .MAX_RETRIES         (3)
  ) dut (
    .refclk          (refclk),
    .rst             (rst),
    .pll_locked      (pll_locked),
    .clear_status    (clear_status),
    .pll_rst         (pll_rst),
    .sys_rst         (sys_rst),
    .sys_rst_n       (sys_rst_n),
    .ready           (ready),
    .lock_loss_count (lock_loss_count),
    .timeout_err     (timeout_err),
    .fault           (fault),
    .fsm_state       (fsm_state)
  );

  // Driver tasks
  task automatic step();
    @(negedge refclk);
  endtask

  task automatic apply_reset();
    rst          = 1'b1;
    pll_locked   = 1'b0;
    clear_status = 1'b0;
    repeat (3) step();
    rst = 1'b0;
  endtask

  // Count edges until sys_rst falls (bounded)
  task automatic wait_release(output int n);
    n = 0;
    while (n < 60 && sys_rst !== 1'b0) begin
      step();
      n++;
    end
  endtask

  // Count edges until sys_rst rises (bounded)
  task automatic wait_assert(output int n);
    n = 0;
    while (n < 20 && sys_rst !== 1'b1) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    pll_locked   = 1'b0;
    clear_status = 1'b0;
    step();
    step();
    total++;
    if ({pll_rst, sys_rst, sys_rst_n, ready, timeout_err, fault} !== 6'b110000) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 110000",
               {pll_rst, sys_rst, sys_rst_n, ready, timeout_err, fault});
    end
    total++;
    if (lock_loss_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_count: got %0d want 0", lock_loss_count);
    end
    total++;
    if (fsm_state !== ST_PLL_RST) begin
      bad++;
      $display("FAIL reset_state: got %0d want %0d", fsm_state, ST_PLL_RST);
    end
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      total++;
      if (pll_rst !== (k <= 3)) begin
        bad++;
        $display("FAIL pll_rst_pulse edge %0d: got %b want %b", k, pll_rst, (k <= 3));
      end
    end
  endtask

  task automatic test_lock_release();
    int n;
    apply_reset();
    repeat (10) step();
    pll_locked = 1'b1;
    exp_q.push_back(32'(LAT));
    wait_release(n);
    exp_v = exp_q.pop_front();
    total++;
    if (sys_rst !== 1'b0) begin
      bad++;
      $display("FAIL lock_release_timeout: sys_rst=%b after %0d edges, want fall at %0d",
               sys_rst, n, exp_v);
    end else if (32'(n) !== exp_v) begin
      bad++;
      $display("FAIL lock_release_latency: got %0d want %0d", n, exp_v);
    end
    total++;
    if ({ready, sys_rst_n, pll_rst} !== 3'b110) begin
      bad++;
      $display("FAIL run_outputs: got %b want 110", {ready, sys_rst_n, pll_rst});
    end
    total++;
    if (fsm_state !== ST_RUN) begin
      bad++;
      $display("FAIL run_state: got %0d want %0d", fsm_state, ST_RUN);
    end
  endtask

  task automatic test_glitch();
    int n;
    apply_reset();
    repeat (10) step();
    pll_locked = 1'b1;
    repeat (7) step();
    pll_locked = 1'b0;   // one sampled low while in STABLE
    step();
    pll_locked = 1'b1;
    exp_q.push_back(32'(8 + LAT));
    wait_release(n);
    exp_v = exp_q.pop_front();
    total++;
    if (sys_rst !== 1'b0 || 32'(8 + n) !== exp_v) begin
      bad++;
      $display("FAIL glitch_release: got %0d edges (sys_rst=%b) want %0d", 8 + n, sys_rst, exp_v);
    end
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL glitch_ready: got %b want 1", ready);
    end
  endtask

  task automatic test_lock_loss();
    int n;
    for (int i = 1; i <= 2; i++) begin
      pll_locked = 1'b0;
      exp_q.push_back(32'(i));
      wait_assert(n);
      exp_v = exp_q.pop_front();
      total++;
      if (sys_rst !== 1'b1 || n > 3) begin
        bad++;
        $display("FAIL loss_latency %0d: got %0d edges (sys_rst=%b) want <=3", i, n, sys_rst);
      end
      total++;
      if (32'(lock_loss_count) !== exp_v || ready !== 1'b0) begin
        bad++;
        $display("FAIL loss_count %0d: got %0d ready=%b want %0d ready=0",
                 i, lock_loss_count, ready, exp_v);
      end
      pll_locked = 1'b1;
      exp_q.push_back(32'(LAT));
      wait_release(n);
      exp_v = exp_q.pop_front();
      total++;
      if (sys_rst !== 1'b0 || 32'(n) !== exp_v) begin
        bad++;
        $display("FAIL relock_latency %0d: got %0d (sys_rst=%b) want %0d", i, n, sys_rst, exp_v);
      end
    end
  endtask

  task automatic test_clear_status();
    int n;
    pll_locked = 1'b0;
    step();
    step();
    clear_status = 1'b1;   // coincides with the edge that records the loss
    step();
    clear_status = 1'b0;
    exp_q.push_back(32'd1);
    exp_v = exp_q.pop_front();
    total++;
    if (32'(lock_loss_count) !== exp_v || sys_rst !== 1'b1) begin
      bad++;
      $display("FAIL clear_coincident: got %0d sys_rst=%b want %0d sys_rst=1",
               lock_loss_count, sys_rst, exp_v);
    end
    pll_locked = 1'b1;
    wait_release(n);
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    exp_q.push_back(32'd0);
    exp_v = exp_q.pop_front();
    total++;
    if (32'(lock_loss_count) !== exp_v || timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL clear_separate: got %0d err=%b want %0d err=0",
               lock_loss_count, timeout_err, exp_v);
    end
  endtask

  task automatic test_timeout();
    logic prev;
    int   last_rise;
    apply_reset();
    prev      = pll_rst;
    last_rise = 0;
    for (int t = 1; t <= 3; t++) exp_q.push_back(32'(t * PERIOD));
`ifndef PLL_RSTCTRL_RETRY_LIMIT_EN
    exp_q.push_back(32'(4 * PERIOD));
`endif
    for (int k = 1; k <= 225; k++) begin
      step();
      if (pll_rst === 1'b1 && prev === 1'b0) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL pll_rst_rise: unexpected rise at edge %0d", k);
        end else begin
          exp_v = exp_q.pop_front();
          if (32'(k) !== exp_v) begin
            bad++;
            $display("FAIL pll_rst_rise: got edge %0d want %0d", k, exp_v);
          end
        end
        last_rise = k;
      end
      if (pll_rst === 1'b0 && prev === 1'b1) begin
        total++;
        if (k - last_rise !== 4) begin
          bad++;
          $display("FAIL pll_rst_width: got %0d want 4", k - last_rise);
        end
      end
      prev = pll_rst;
      if (k == PERIOD - 1 || k == PERIOD) begin
        total++;
        if (timeout_err !== (k == PERIOD)) begin
          bad++;
          $display("FAIL timeout_err edge %0d: got %b want %b", k, timeout_err, (k == PERIOD));
        end
      end
      if (k == 59) clear_status = 1'b1;
      if (k == 60) begin
        clear_status = 1'b0;
        total++;
        if (timeout_err !== 1'b0) begin
          bad++;
          $display("FAIL timeout_clear: got %b want 0", timeout_err);
        end
      end
      if (k == 2 * PERIOD - 1) clear_status = 1'b1;
      if (k == 2 * PERIOD) begin
        clear_status = 1'b0;
        total++;
        if (timeout_err !== 1'b1) begin
          bad++;
          $display("FAIL timeout_clear_coincident: got %b want 1", timeout_err);
        end
      end
`ifdef PLL_RSTCTRL_RETRY_LIMIT_EN
      if (k == 4 * PERIOD || k == 225) begin
        total++;
        if ({fault, pll_rst, sys_rst} !== 3'b101 || fsm_state !== ST_FAULT) begin
          bad++;
          $display("FAIL fault_entry edge %0d: got fault/pll_rst/sys_rst=%b state=%0d want 101 state=%0d",
                   k, {fault, pll_rst, sys_rst}, fsm_state, ST_FAULT);
        end
      end
      if (k == 4 * PERIOD + 2) pll_locked = 1'b1;  // lock must not leave FAULT
`else
      if (k == 4 * PERIOD) begin
        total++;
        if (fault !== 1'b0) begin
          bad++;
          $display("FAIL fault_tied: got %b want 0", fault);
        end
      end
`endif
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pll_rst_missing: %0d expected rises not seen", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    #1;
    total++;
    if ({pll_rst, sys_rst, fault, timeout_err, ready} !== 5'b11000 || fsm_state !== ST_PLL_RST) begin
      bad++;
      $display("FAIL reset_mid: got %b state=%0d want 11000 state=%0d",
               {pll_rst, sys_rst, fault, timeout_err, ready}, fsm_state, ST_PLL_RST);
    end
    step();
    rst = 1'b0;
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_lock_release();
    test_glitch();
    test_lock_loss();
    test_clear_status();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
